rf_init_bypass: RTL

RF_INIT_BYPASS -- requirements
Module: rf_init_bypass

---
 rtl/rv_pkg.sv | 12 +
 rtl/rf_init_bypass.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the register-file front end: FSM encoding and
// the hard-wired zero register index.
package rv_pkg;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/rf_init_bypass.sv
// Front end for an external 2R1W SRAM register file: zeroes every entry after
// reset, masks x0, and forwards same-cycle writes to the one-cycle-late reads.
module rf_init_bypass
  import rv_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addrA,
  input  logic [ADDR_WIDTH-1:0] i_addrB,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_wen,
  output logic [DATA_WIDTH-1:0] o_rdataA,
  output logic [DATA_WIDTH-1:0] o_rdataB,
  output logic                  o_ready,
  output logic [ADDR_WIDTH-1:0] o_sram_addrA,
  output logic [ADDR_WIDTH-1:0] o_sram_addrB,
  output logic [ADDR_WIDTH-1:0] o_sram_waddr,
  output logic [DATA_WIDTH-1:0] o_sram_wdata,
  output logic                  o_sram_wen,
  input  logic [DATA_WIDTH-1:0] i_sram_rdataA,
  input  logic [DATA_WIDTH-1:0] i_sram_rdataB,
  output logic                  dbg_state
);

  // o_ready is a level, not a handshake: while it is low the pipeline's
  // writes are discarded and reads return zero; once high it stays high
  // until the next reset.

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ra_zero_q, rb_zero_q;
  logic                  ra_byp_q, rb_byp_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ready;
  logic                  wr_nonzero;

  assign ready      = (state_q == RF_READY);
  assign wr_nonzero = i_wen && (i_waddr != ZERO_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter stops on the last address so it never wraps into a second sweep.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_INIT: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = RF_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RF_READY: begin
        state_d = RF_READY;
      end
      default: begin
        state_d = RF_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    o_sram_wen   = 1'b1;
    o_sram_waddr = cnt_q;
    o_sram_wdata = '0;
    if (ready) begin
      o_sram_wen   = wr_nonzero;
      o_sram_waddr = i_waddr;
      o_sram_wdata = i_wdata;
    end
  end

  assign o_sram_addrA = i_addrA;
  assign o_sram_addrB = i_addrB;
  assign o_ready      = ready;
  assign dbg_state    = logic'(state_q);

  // During INIT the zero flags are forced so the first READY cycle, which
  // shows reads issued in the last INIT cycle, still returns zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_zero_q <= 1'b0;
      rb_zero_q <= 1'b0;
      ra_byp_q  <= 1'b0;
      rb_byp_q  <= 1'b0;
      wdata_q   <= '0;
    end else if (!ready) begin
      ra_zero_q <= 1'b1;
      rb_zero_q <= 1'b1;
      ra_byp_q  <= 1'b0;
      rb_byp_q  <= 1'b0;
      wdata_q   <= '0;
    end else begin
      ra_zero_q <= (i_addrA == ZERO_ADDR);
      rb_zero_q <= (i_addrB == ZERO_ADDR);
      ra_byp_q  <= wr_nonzero && (i_waddr == i_addrA);
      rb_byp_q  <= wr_nonzero && (i_waddr == i_addrB);
      wdata_q   <= i_wdata;
    end
  end

  always_comb begin
    o_rdataA = i_sram_rdataA;
    if (!ready || ra_zero_q) begin
      o_rdataA = '0;
    end else if (ra_byp_q) begin
      o_rdataA = wdata_q;
    end
  end

  always_comb begin
    o_rdataB = i_sram_rdataB;
    if (!ready || rb_zero_q) begin
      o_rdataB = '0;
    end else if (rb_byp_q) begin
      o_rdataB = wdata_q;
    end
  end

endmodule
